// File: rtl/vga_timing.sv
// VGA raster timing generator: pixel-rate divider, h/v counters, sync decode
// and a one-pixel-delayed output stage that blanks colour outside the visible area.
module vga_timing #(
    parameter int CLK_DIV     = 2,
    parameter int H_VISIBLE   = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_VISIBLE   = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit SYNC_ACTIVE = 1'b0
) (
    input  logic       Clk,
    input  logic       Reset,
    output logic [9:0] Hcount,
    output logic [8:0] Vcount,
    input  logic [7:0] Red_in,
    input  logic [7:0] Green_in,
    input  logic [7:0] Blue_in,
    output logic [7:0] Red,
    output logic [7:0] Green,
    output logic [7:0] Blue,
    output logic       Hsync,
    output logic       Vsync,
    output logic       Disp_en,
    output logic       Frame_tick
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [1:0] DIV_LAST   = 2'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END  = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END = 10'(V_VISIBLE + V_FP + V_SYNC);

    logic [1:0] div;
    logic [9:0] h;
    logic [9:0] v;
    logic       pix_en;
    logic       h_wrap;
    logic       v_wrap;
    logic       h_sync_cond;
    logic       v_sync_cond;

    // With CLK_DIV = 1 the divider sits at 0, which is also its last value,
    // so pix_en is asserted on every clock.
    assign pix_en = (div == DIV_LAST);
    assign h_wrap = (h == H_LAST);
    assign v_wrap = (v == V_LAST);

    assign Hcount  = h;
    assign Vcount  = v[8:0];
    assign Disp_en = (h < H_VIS_END) && (v < V_VIS_END);

    assign h_sync_cond = (h >= H_SYNC_BEG) && (h < H_SYNC_END);
    assign v_sync_cond = (v >= V_SYNC_BEG) && (v < V_SYNC_END);

    assign Frame_tick = pix_en && h_wrap && v_wrap && !Reset;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            div <= '0;
        end else if (pix_en) begin
            div <= '0;
        end else begin
            div <= div + 2'd1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            h <= '0;
            v <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                h <= '0;
                v <= v_wrap ? 10'd0 : v + 10'd1;
            end else begin
                h <= h + 10'd1;
            end
        end
    end

    // Output stage captures the current pixel, so every output lags the
    // counters by exactly one pixel period and all five stay aligned.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Red   <= '0;
            Green <= '0;
            Blue  <= '0;
            Hsync <= ~SYNC_ACTIVE;
            Vsync <= ~SYNC_ACTIVE;
        end else if (pix_en) begin
            Red   <= Disp_en ? Red_in   : 8'd0;
            Green <= Disp_en ? Green_in : 8'd0;
            Blue  <= Disp_en ? Blue_in  : 8'd0;
            Hsync <= h_sync_cond ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            Vsync <= v_sync_cond ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule
